// File: rtl/rst_seq.sv
// Reset sequencer for the wb_clk domain.
// Sequences DDR2, Wishbone and peripheral reset release after PLL lock.
module rst_seq #(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int CALIB_TIMEOUT      = 1048576,
  parameter int MAX_RETRIES        = 3,
  parameter int RST_STRETCH        = 16,
  parameter int CNT_W              = 21
) (
  input  logic       wb_clk_i,
  input  logic       rst_n_i,
  input  logic       plls_locked_i,
  input  logic       ddr2_calib_done_i,
  output logic       ddr2_if_rst_o,
  output logic       wb_rst_o,
  output logic       periph_rst_o,
  output logic [2:0] seq_state_o,
  output logic [1:0] retry_cnt_o,
  output logic       fail_o
);

  localparam int RW = 8;

  localparam logic [CNT_W-1:0] LOCK_LAST =
    CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAL_LAST =
    CNT_W'(CALIB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STR_LAST =
    CNT_W'(RST_STRETCH - 1);
  localparam logic [RW-1:0] RETRY_MAX =
    RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HOLD  = 3'd1,
    CALIB = 3'd2,
    WB_UP = 3'd3,
    RUN   = 3'd4,
    FAIL  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic             ddr_rst_q, ddr_rst_d;
  logic             wb_rst_q, wb_rst_d;
  logic             per_rst_q, per_rst_d;
  logic             fail_q, fail_d;

  logic lock_m_q, lock_s_q;
  logic cal_m_q, cal_s_q;

  // Two-flop synchronisers for the asynchronous status inputs
  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_m_q <= 1'b0;
      lock_s_q <= 1'b0;
      cal_m_q  <= 1'b0;
      cal_s_q  <= 1'b0;
    end else begin
      lock_m_q <= plls_locked_i;
      lock_s_q <= lock_m_q;
      cal_m_q  <= ddr2_calib_done_i;
      cal_s_q  <= cal_m_q;
    end
  end

  logic [CNT_W-1:0] cnt_inc;
  logic [RW-1:0]    retry_inc;

  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign retry_inc = (retry_q == '1) ? retry_q
                   : retry_q + RW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    if (state_q != FAIL && !lock_s_q) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cnt_q == LOCK_LAST) begin
            state_d = CALIB;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        CALIB: begin
          cnt_d = cnt_inc;
          if (cal_s_q) begin
            state_d = WB_UP;
            cnt_d   = '0;
          end else if (cnt_q == CAL_LAST) begin
            cnt_d = '0;
            if (retry_q < RETRY_MAX) begin
              state_d = HOLD;
              retry_d = retry_inc;
            end else begin
              state_d = FAIL;
            end
          end
        end
        HOLD: begin
          if (cnt_q == STR_LAST) begin
            state_d = CALIB;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        WB_UP: begin
          if (cnt_q == STR_LAST) begin
            state_d = RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        RUN: begin
          if (!cal_s_q) begin
            state_d = HOLD;
            cnt_d   = '0;
            retry_d = retry_inc;
          end
        end
        FAIL: begin
          state_d = FAIL;
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode the next state so they switch with it
  always_comb begin
    ddr_rst_d = 1'b1;
    wb_rst_d  = 1'b1;
    per_rst_d = 1'b1;
    fail_d    = 1'b0;
    unique case (state_d)
      CALIB: ddr_rst_d = 1'b0;
      WB_UP: begin
        ddr_rst_d = 1'b0;
        wb_rst_d  = 1'b0;
      end
      RUN: begin
        ddr_rst_d = 1'b0;
        wb_rst_d  = 1'b0;
        per_rst_d = 1'b0;
      end
      FAIL:    fail_d = 1'b1;
      default: fail_d = 1'b0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      retry_q   <= '0;
      ddr_rst_q <= 1'b1;
      wb_rst_q  <= 1'b1;
      per_rst_q <= 1'b1;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      ddr_rst_q <= ddr_rst_d;
      wb_rst_q  <= wb_rst_d;
      per_rst_q <= per_rst_d;
      fail_q    <= fail_d;
    end
  end

  assign ddr2_if_rst_o = ddr_rst_q;
  assign wb_rst_o      = wb_rst_q;
  assign periph_rst_o  = per_rst_q;
  assign fail_o        = fail_q;
  assign seq_state_o   = state_q;
  assign retry_cnt_o   = (retry_q > RW'(3)) ? 2'd3
                       : retry_q[1:0];

endmodule

// File: tb/tb_rst_seq.sv
// Randomised scoreboard bench for rst_seq.
// Expected outputs come from an elapsed-time model of the sequence.
module tb_rst_seq;

  localparam int LOCK = 8;
  localparam int TO   = 64;
  localparam int MAXR = 2;
  localparam int STR  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic lock_in = 1'b0;
  logic cal_in = 1'b0;
  logic ddr, wb, per, fl;
  logic [2:0] st;
  logic [1:0] rc;

  always #5 clk = ~clk;

  rst_seq #(
    .LOCK_STABLE_CYCLES(LOCK),
    .CALIB_TIMEOUT(TO),
    .MAX_RETRIES(MAXR),
    .RST_STRETCH(STR),
    .CNT_W(21)
  ) dut (
    .wb_clk_i(clk),
    .rst_n_i(rst_n),
    .plls_locked_i(lock_in),
    .ddr2_calib_done_i(cal_in),
    .ddr2_if_rst_o(ddr),
    .wb_rst_o(wb),
    .periph_rst_o(per),
    .seq_state_o(st),
    .retry_cnt_o(rc),
    .fail_o(fl)
  );

  typedef struct packed {
    logic       ddr;
    logic       wb;
    logic       per;
    logic       fl;
    logic [2:0] st;
    logic [1:0] rc;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // Model: phase number, edge index at phase entry, retries used
  int ph, ent, retries, n;
  bit l1, ls, c1, cs;

  function automatic exp_t exp_of();
    exp_t e;
    e.ddr = 1'b1;
    e.wb  = 1'b1;
    e.per = 1'b1;
    e.fl  = (ph == 5);
    e.st  = 3'(ph);
    e.rc  = (retries > 3) ? 2'd3 : 2'(retries);
    if (ph == 2) e.ddr = 1'b0;
    if (ph == 3) begin
      e.ddr = 1'b0;
      e.wb  = 1'b0;
    end
    if (ph == 4) begin
      e.ddr = 1'b0;
      e.wb  = 1'b0;
      e.per = 1'b0;
    end
    return e;
  endfunction

  function automatic void go(int p);
    ph  = p;
    ent = n;
  endfunction

  function automatic void model_reset();
    ph = 0;
    ent = n;
    retries = 0;
    l1 = 0; ls = 0; c1 = 0; cs = 0;
  endfunction

  function automatic void model_step();
    int el;
    n++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    el = n - ent;
    if (ph != 5 && !ls) go(0);
    else begin
      case (ph)
        0: if (el == LOCK) go(2);
        2: begin
          if (cs) go(3);
          else if (el == TO) begin
            if (retries < MAXR) begin
              retries++;
              go(1);
            end else go(5);
          end
        end
        1: if (el == STR) go(2);
        3: if (el == STR) go(4);
        4: if (!cs) begin
          retries++;
          go(1);
        end
        default: ;
      endcase
    end
    ls = l1; l1 = lock_in;
    cs = c1; c1 = cal_in;
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step();
    q.push_back(exp_of());
    #1;
  endtask

  task automatic hold(int k, bit l, bit c);
    lock_in = l;
    cal_in = c;
    for (int i = 0; i < k; i++) cyc();
  endtask

  task automatic do_reset(int k);
    exp_t got;
    q.delete();
    rst_n = 1'b0;
    model_reset();
    #1;
    got = {ddr, wb, per, fl, st, rc};
    total++;
    if (got !== {1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 2'd0}) begin
      bad++;
      $display("FAIL async_reset got=%b want=1110_000_00", got);
    end
    for (int i = 0; i < k; i++) cyc();
    rst_n = 1'b1;
  endtask

  logic p_ddr = 1'b1, p_wb = 1'b1, p_per = 1'b1;

  always @(negedge clk) begin
    exp_t e, got;
    if (q.size() > 0) begin
      e = q.pop_front();
      got = {ddr, wb, per, fl, st, rc};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL outs t=%0t got ddr%b wb%b per%b fl%b st%0d rc%0d want ddr%b wb%b per%b fl%b st%0d rc%0d",
          $time, ddr, wb, per, fl, st, rc,
          e.ddr, e.wb, e.per, e.fl, e.st, e.rc);
      end
      if (p_wb && !wb) begin
        total++;
        if (p_ddr !== 1'b0) begin
          bad++;
          $display("FAIL order_wb t=%0t ddr_prev=%b want 0", $time, p_ddr);
        end
      end
      if (p_per && !per) begin
        total++;
        if (p_wb !== 1'b0) begin
          bad++;
          $display("FAIL order_per t=%0t wb_prev=%b want 0", $time, p_wb);
        end
      end
    end
    p_ddr = ddr;
    p_wb = wb;
    p_per = per;
  end

  initial begin
    n = 0;
    model_reset();
    #2;
    do_reset(3);
    // normal bring-up, then calib drop, then lock drop
    hold(30, 1'b1, 1'b0);
    hold(30, 1'b1, 1'b1);
    hold(10, 1'b1, 1'b0);
    hold(30, 1'b1, 1'b1);
    hold(5, 1'b0, 1'b1);
    hold(40, 1'b1, 1'b1);
    // glitchy lock then calibration never completes
    do_reset(2);
    hold(5, 1'b1, 1'b0);
    hold(1, 1'b0, 1'b0);
    hold(300, 1'b1, 1'b0);
    hold(20, 1'b1, 1'b1);
    do_reset(2);
    // reset while in CALIB, then clean restart
    hold(20, 1'b1, 1'b0);
    do_reset(2);
    hold(60, 1'b1, 1'b1);
    for (int s = 0; s < 25; s++) begin
      if ($urandom_range(0, 9) == 0) do_reset(2);
      hold($urandom_range(1, 80),
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
